// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 memory/IO bridge.
//   ADDR_SW_HEX : switch read / hex-display write register
//   ADDR_LED    : LED register
//   bridge_state_t : bridge FSM state encoding
package slc3_pkg;

   localparam logic [15:0] ADDR_SW_HEX = 16'hFFFF;
   localparam logic [15:0] ADDR_LED    = 16'hFFFE;

   // Fixed encodings so state values stay stable for any legacy decode.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MEM_RD = 3'd1;
   localparam logic [2:0] S_MEM_WR = 3'd2;
   localparam logic [2:0] S_IO     = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_HOLD   = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_MEM_RD = S_MEM_RD,
      ST_MEM_WR = S_MEM_WR,
      ST_IO     = S_IO,
      ST_DONE   = S_DONE,
      ST_HOLD   = S_HOLD
   } bridge_state_t;

endpackage

// File: rtl/slc3_mem_bridge_if.sv
// CPU memory-port bundle.
//   master : CPU side (drives ADDR/Data_from_CPU/OE/WE)
//   slave  : bridge side (returns Data_to_CPU and the Mem_Ready pulse)
interface slc3_mem_bridge_if;
   logic [15:0] ADDR;
   logic [15:0] Data_from_CPU;
   logic        OE;
   logic        WE;
   logic [15:0] Data_to_CPU;
   logic        Mem_Ready;

   modport master (output ADDR, Data_from_CPU, OE, WE,
                   input  Data_to_CPU, Mem_Ready);
   modport slave  (input  ADDR, Data_from_CPU, OE, WE,
                   output Data_to_CPU, Mem_Ready);
endinterface

// File: rtl/sw_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
//   Clk, Reset_n : clock, async active-low reset (flops clear to 0)
//   d            : asynchronous input
//   q            : synchronized output, two cycles behind d
module sw_sync #(
   parameter int W = 10
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/slc3_mem_bridge.sv
// Bridge between the SLC-3 CPU memory port and on-chip test memory plus
// two memory-mapped registers (switches/hex at 0xFFFF, LEDs at 0xFFFE).
//   Clk, Reset_n  : clock, async active-low reset
//   cpu           : CPU port (ADDR, Data_from_CPU, OE, WE -> Data_to_CPU, Mem_Ready)
//   mem_*         : test-memory port, fixed read latency RD_LATENCY (1..3)
//   SW            : raw board switches (asynchronous)
//   HEX_Data      : hex-display register
//   LED_Data      : LED register
// Each request yields exactly one Mem_Ready pulse; the bridge then waits
// for OE/WE to drop before accepting another request.
module slc3_mem_bridge
   import slc3_pkg::*;
#(
   parameter int MEM_AW     = 10,
   parameter int RD_LATENCY = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   slc3_mem_bridge_if.slave  cpu,
   output logic [MEM_AW-1:0] mem_address,
   output logic [15:0]       mem_data,
   output logic              mem_rden,
   output logic              mem_wren,
   input  logic [15:0]       mem_readout,
   input  logic [9:0]        SW,
   output logic [15:0]       HEX_Data,
   output logic [9:0]        LED_Data
);

   localparam logic [1:0] LAT = 2'(RD_LATENCY);

   bridge_state_t state;
   logic [1:0]    cnt;
   logic [9:0]    sw_q;
   logic          addr_io;
   logic          addr_mem;

   sw_sync #(.W(10)) u_sw_sync (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .d       (SW),
      .q       (sw_q)
   );

   assign mem_address = cpu.ADDR[MEM_AW-1:0];
   assign mem_data    = cpu.Data_from_CPU;

   assign addr_io  = (cpu.ADDR == ADDR_SW_HEX) || (cpu.ADDR == ADDR_LED);
   assign addr_mem = ((cpu.ADDR >> MEM_AW) == 16'd0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         cpu.Data_to_CPU <= '0;
         cpu.Mem_Ready   <= 1'b0;
         HEX_Data        <= '0;
         LED_Data        <= '0;
         mem_rden        <= 1'b0;
         mem_wren        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu.WE || cpu.OE) begin
                  // Unmapped addresses also go to IO, where they read as 0
                  // and writes are ignored.
                  if (!addr_io && addr_mem) begin
                     if (cpu.WE) begin
                        state    <= ST_MEM_WR;
                        mem_wren <= 1'b1;
                     end else begin
                        state    <= ST_MEM_RD;
                        mem_rden <= 1'b1;
                        cnt      <= '0;
                     end
                  end else begin
                     state <= ST_IO;
                  end
               end
            end
            ST_MEM_RD: begin
               // rden stays up for LAT cycles; one more cycle lets the
               // registered memory output settle before capture.
               if (cnt == LAT) begin
                  cpu.Data_to_CPU <= mem_readout;
                  cpu.Mem_Ready   <= 1'b1;
                  state           <= ST_DONE;
               end else begin
                  cnt      <= cnt + 2'd1;
                  mem_rden <= ((cnt + 2'd1) != LAT);
               end
            end
            ST_MEM_WR: begin
               mem_wren      <= 1'b0;
               cpu.Mem_Ready <= 1'b1;
               state         <= ST_DONE;
            end
            ST_IO: begin
               if (cpu.WE) begin
                  if (cpu.ADDR == ADDR_SW_HEX)
                     HEX_Data <= cpu.Data_from_CPU;
                  else if (cpu.ADDR == ADDR_LED)
                     LED_Data <= cpu.Data_from_CPU[9:0];
               end else begin
                  if (cpu.ADDR == ADDR_SW_HEX)
                     cpu.Data_to_CPU <= {6'b0, sw_q};
                  else if (cpu.ADDR == ADDR_LED)
                     cpu.Data_to_CPU <= {6'b0, LED_Data};
                  else
                     cpu.Data_to_CPU <= 16'h0000;
               end
               cpu.Mem_Ready <= 1'b1;
               state         <= ST_DONE;
            end
            ST_DONE: begin
               cpu.Mem_Ready <= 1'b0;
               state         <= ST_HOLD;
            end
            ST_HOLD: begin
               if (!cpu.OE && !cpu.WE)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
